// File: rtl/abr_keccak_entropy_pkg.sv
// Shared constants, sparse state encoding and LFSR helper for the Keccak masking entropy source.
// Provides ABR_PRIM_FLOP_SPARSE_FSM when the surrounding codebase has not already defined it.
`ifndef ABR_PRIM_FLOP_SPARSE_FSM
`define ABR_PRIM_FLOP_SPARSE_FSM(state_d, state_q, state_t, rst_val) \
  always_ff @(posedge clk_i or negedge rst_n) begin \
    if (!rst_n) state_q <= rst_val; \
    else        state_q <= state_d; \
  end
`endif

package abr_keccak_entropy_pkg;

  localparam int unsigned ChunkW      = 32;
  localparam int unsigned StateW      = 6;
  localparam logic [31:0] LfsrPoly    = 32'h8020_0003;
  localparam logic [31:0] NonZeroSeed = 32'h1;

  // Pairwise Hamming distance >= 3 between all legal encodings.
  typedef enum logic [StateW-1:0] {
    StIdle          = 6'b001011,
    StSeed          = 6'b110001,
    StFill          = 6'b010110,
    StRun           = 6'b101100,
    StTerminalError = 6'b111111
  } keccak_ent_st_e;

  function automatic logic [ChunkW-1:0] lfsr_next(input logic [ChunkW-1:0] s);
    return s[0] ? ((s >> 1) ^ LfsrPoly) : (s >> 1);
  endfunction

endpackage

// File: rtl/abr_keccak_entropy_if.sv
// Seed request/acknowledge port and round entropy handshake of the Keccak entropy source.
interface abr_keccak_entropy_if #(
  parameter int unsigned RandW = 800
);
  import abr_keccak_entropy_pkg::*;

  logic              seed_req_o;
  logic              seed_ack_i;
  logic [ChunkW-1:0] seed_i;
  logic              rand_valid_o;
  logic              rand_early_o;
  logic [RandW-1:0]  rand_data_o;
  logic              rand_aux_o;
  logic              rand_consumed_i;

  // Entropy source side.
  modport slave (
    output seed_req_o, rand_valid_o, rand_early_o, rand_data_o, rand_aux_o,
    input  seed_ack_i, seed_i, rand_consumed_i
  );

  // Seed provider / round side.
  modport master (
    input  seed_req_o, rand_valid_o, rand_early_o, rand_data_o, rand_aux_o,
    output seed_ack_i, seed_i, rand_consumed_i
  );

endinterface

// File: rtl/abr_keccak_entropy_lfsr.sv
// One 32-bit Galois LFSR chunk; clear beats load beats step, zero loads are forced non-zero.
module abr_keccak_entropy_lfsr
  import abr_keccak_entropy_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ChunkW-1:0] load_val,
  input  logic              step,
  input  logic              clr,
  output logic [ChunkW-1:0] state_o
);

  logic [ChunkW-1:0] r_state;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
    end else if (clr) begin
      r_state <= '0;
    end else if (load) begin
      r_state <= (load_val == '0) ? NonZeroSeed : load_val;
    end else if (step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign state_o = r_state;

endmodule

// File: rtl/abr_keccak_entropy.sv
// Masking-randomness source for the masked Keccak round: seeds a bank of LFSR chunks, serves words.
// Optional periodic reseeding is enabled with `define ABR_KECCAK_ENTROPY_RESEED_EN.
module abr_keccak_entropy
  import abr_keccak_entropy_pkg::*;
#(
  parameter int unsigned Width          = 1600,
  parameter int unsigned ReseedInterval = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_n,
  input  logic                        zeroize,
  input  logic                        en_i,
  abr_keccak_entropy_if.slave         ent,
  output logic                        consume_error_o,
  output logic                        fsm_error_o
);

  localparam int unsigned RandW     = Width / 2;
  localparam int unsigned NumChunks = RandW / ChunkW;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  if ((RandW % ChunkW) != 0 || NumChunks == 0) begin : g_bad_width
    $error("Width/2 must be a non-zero multiple of 32");
  end
  if (ReseedInterval < 1 || ReseedInterval > 65535) begin : g_bad_interval
    $error("ReseedInterval must be in 1..65535");
  end

  keccak_ent_st_e    r_state;
  keccak_ent_st_e    w_state_d;
  logic [CntW-1:0]   r_seed_cnt;
  logic              r_cons_err;
  logic              w_seed_req;
  logic              w_valid;
  logic              w_early;
  logic              w_step;
  logic              w_seed_xfer;
  logic              w_seed_cnt_clr;
  logic              w_fsm_err;
  logic              w_aux;
  logic [RandW-1:0]  w_chunks;

`ifdef ABR_KECCAK_ENTROPY_RESEED_EN
  localparam int unsigned ConsW = 16;
  logic [ConsW-1:0]  r_cons_cnt;
  logic              w_cons_clr;
`endif

  // Next-state and control decode.
  always_comb begin
    w_state_d      = r_state;
    w_seed_req     = 1'b0;
    w_valid        = 1'b0;
    w_early        = 1'b0;
    w_step         = 1'b0;
    w_seed_xfer    = 1'b0;
    w_seed_cnt_clr = 1'b0;
    w_fsm_err      = 1'b0;
`ifdef ABR_KECCAK_ENTROPY_RESEED_EN
    w_cons_clr     = 1'b0;
`endif
    case (r_state)
      StIdle: begin
        if (en_i) begin
          w_seed_cnt_clr = 1'b1;
          w_state_d      = StSeed;
        end
      end
      StSeed: begin
        w_seed_req = 1'b1;
        if (ent.seed_ack_i) begin
          w_seed_xfer = 1'b1;
          if (r_seed_cnt == CntW'(NumChunks - 1)) begin
            w_seed_cnt_clr = 1'b1;
            w_state_d      = StFill;
          end
        end
      end
      StFill: begin
        w_early   = 1'b1;
        w_step    = 1'b1;
        w_state_d = StRun;
      end
      StRun: begin
        w_valid = 1'b1;
        if (ent.rand_consumed_i) begin
          w_step  = 1'b1;
          w_early = 1'b1;
`ifdef ABR_KECCAK_ENTROPY_RESEED_EN
          if (r_cons_cnt == ConsW'(ReseedInterval - 1)) begin
            w_cons_clr     = 1'b1;
            w_seed_cnt_clr = 1'b1;
            w_state_d      = StSeed;
          end
`endif
        end
      end
      StTerminalError: begin
        w_fsm_err = 1'b1;
      end
      default: begin
        w_fsm_err = 1'b1;
        w_state_d = StTerminalError;
      end
    endcase
    if (zeroize) begin
      w_state_d = StIdle;
    end
  end

  `ABR_PRIM_FLOP_SPARSE_FSM(w_state_d, r_state, keccak_ent_st_e, StIdle)

  // Seed word index; cleared on entry to seeding and after the last word.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_seed_cnt <= '0;
    end else if (zeroize || w_seed_cnt_clr) begin
      r_seed_cnt <= '0;
    end else if (w_seed_xfer) begin
      r_seed_cnt <= r_seed_cnt + CntW'(1);
    end
  end

`ifdef ABR_KECCAK_ENTROPY_RESEED_EN
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cons_cnt <= '0;
    end else if (zeroize || w_cons_clr) begin
      r_cons_cnt <= '0;
    end else if (r_state == StRun && ent.rand_consumed_i) begin
      r_cons_cnt <= r_cons_cnt + ConsW'(1);
    end
  end
`endif

  // Sticky: the round consumed data that was not being offered.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cons_err <= 1'b0;
    end else if (zeroize) begin
      r_cons_err <= 1'b0;
    end else if (ent.rand_consumed_i && r_state != StRun) begin
      r_cons_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NumChunks; i++) begin : g_chunk
    abr_keccak_entropy_lfsr u_lfsr (
      .clk_i    (clk_i),
      .rst_n    (rst_n),
      .load     (w_seed_xfer && (r_seed_cnt == CntW'(i))),
      .load_val (ent.seed_i),
      .step     (w_step),
      .clr      (zeroize),
      .state_o  (w_chunks[ChunkW*i +: ChunkW])
    );
  end

  always_comb begin
    w_aux = 1'b0;
    for (int unsigned i = 0; i < NumChunks; i++) begin
      w_aux = w_aux ^ w_chunks[ChunkW*i + ChunkW - 1];
    end
  end

  // Rand outputs are forced to zero once the FSM has failed.
  assign ent.seed_req_o   = w_seed_req;
  assign ent.rand_valid_o = w_valid;
  assign ent.rand_early_o = w_early;
  assign ent.rand_data_o  = w_fsm_err ? '0 : w_chunks;
  assign ent.rand_aux_o   = w_aux & ~w_fsm_err;
  assign consume_error_o  = r_cons_err;
  assign fsm_error_o      = w_fsm_err;

endmodule

// File: tb/tb_abr_keccak_entropy.sv
// Self-checking bench for abr_keccak_entropy against a chunk-array reference model.
module tb_abr_keccak_entropy;

  localparam int unsigned Width = 1600;
  localparam int unsigned RandW = Width / 2;
  localparam int          NC    = RandW / 32;
  localparam int          RI    = 4;
  localparam logic [31:0] POLY  = 32'h8020_0003;

  logic clk_i = 1'b0;
  logic rst_n;
  logic zeroize;
  logic en_i;
  logic cons_err;
  logic fsm_err;

  abr_keccak_entropy_if #(.RandW(RandW)) ent_if ();

  abr_keccak_entropy #(.Width(Width), .ReseedInterval(RI)) dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .zeroize         (zeroize),
    .en_i            (en_i),
    .ent             (ent_if),
    .consume_error_o (cons_err),
    .fsm_error_o     (fsm_err)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int m_cons = 0;
  logic [31:0] m_chunk    [NC];
  logic [31:0] seed_words [NC];

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] fb;
    fb = ((s % 2) == 1) ? POLY : 32'h0;
    return (s / 2) ^ fb;
  endfunction

  function automatic logic [RandW-1:0] m_data();
    logic [RandW-1:0] d;
    d = '0;
    for (int i = 0; i < NC; i++) d[32*i +: 32] = m_chunk[i];
    return d;
  endfunction

  function automatic logic m_aux();
    logic a;
    a = 1'b0;
    for (int i = 0; i < NC; i++) a = a ^ m_chunk[i][31];
    return a;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NC; i++) m_chunk[i] = 32'h0;
    m_cons = 0;
  endtask

  task automatic do_zeroize();
    zeroize = 1'b1;
    @(posedge clk_i); #1;
    zeroize = 1'b0;
    model_clear();
  endtask

  task automatic random_words();
    for (int i = 0; i < NC; i++) seed_words[i] = $urandom();
  endtask

  // Seeds all chunks with random ack gaps, then checks fill timing and the first word.
  task automatic seed_and_fill(input bit from_idle);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    if (from_idle) begin
      en_i = 1'b1;
      ent_if.seed_ack_i = 1'b1;
      ent_if.seed_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      total++;
      if (ent_if.seed_req_o !== 1'b0) begin
        bad++; $display("FAIL idle_seed_req got=%b exp=0", ent_if.seed_req_o);
      end
      @(posedge clk_i); #1;
    end
    while (k < NC && cyc < 400) begin
      ent_if.seed_ack_i = ($urandom_range(3) != 0);
      ent_if.seed_i = seed_words[k];
      if (k == 1) en_i = 1'b0;
      @(negedge clk_i);
      total++;
      if ({ent_if.seed_req_o, ent_if.rand_valid_o} !== 2'b10) begin
        bad++; $display("FAIL seeding word=%0d req_valid got=%b exp=10", k,
                        {ent_if.seed_req_o, ent_if.rand_valid_o});
      end
      @(posedge clk_i); #1;
      if (ent_if.seed_ack_i) k++;
      cyc++;
    end
    ent_if.seed_ack_i = 1'b0;
    en_i = 1'b0;
    if (k < NC) begin
      total++; bad++;
      $display("FAIL seed_timeout words=%0d exp=%0d", k, NC);
      return;
    end
    for (int i = 0; i < NC; i++) m_chunk[i] = m_step((seed_words[i] == 32'h0) ? 32'h1 : seed_words[i]);
    @(negedge clk_i);
    total++;
    if ({ent_if.seed_req_o, ent_if.rand_early_o, ent_if.rand_valid_o} !== 3'b010) begin
      bad++; $display("FAIL fill_cycle req_early_valid got=%b exp=010",
                      {ent_if.seed_req_o, ent_if.rand_early_o, ent_if.rand_valid_o});
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    total++;
    if ({ent_if.seed_req_o, ent_if.rand_early_o, ent_if.rand_valid_o} !== 3'b001) begin
      bad++; $display("FAIL first_valid req_early_valid got=%b exp=001",
                      {ent_if.seed_req_o, ent_if.rand_early_o, ent_if.rand_valid_o});
    end
    total++;
    if (ent_if.rand_data_o !== m_data()) begin
      bad++; $display("FAIL first_data chunk0 got=%h exp=%h", ent_if.rand_data_o[31:0], m_chunk[0]);
    end
    total++;
    if (ent_if.rand_aux_o !== m_aux()) begin
      bad++; $display("FAIL first_aux got=%b exp=%b", ent_if.rand_aux_o, m_aux());
    end
    @(posedge clk_i); #1;
  endtask

  // Issues n consumes (optionally with idle gaps), checking every cycle against the model.
  task automatic do_consumes(input int n, input bit gaps, output bit reseeded);
    int done;
    int cyc;
    bit gap;
    done = 0;
    cyc = 0;
    reseeded = 1'b0;
    while (done < n && cyc < 200) begin
      gap = gaps && ($urandom_range(2) == 0);
      ent_if.rand_consumed_i = !gap;
      @(negedge clk_i);
      total++;
      if ({ent_if.rand_valid_o, ent_if.rand_early_o} !== {1'b1, !gap}) begin
        bad++; $display("FAIL run_flags n=%0d valid_early got=%b exp=%b", done,
                        {ent_if.rand_valid_o, ent_if.rand_early_o}, {1'b1, !gap});
      end
      total++;
      if (ent_if.rand_data_o !== m_data() || ent_if.rand_aux_o !== m_aux()) begin
        bad++; $display("FAIL run_data n=%0d chunk0 got=%h exp=%h", done,
                        ent_if.rand_data_o[31:0], m_chunk[0]);
      end
      @(posedge clk_i); #1;
      cyc++;
      if (!gap) begin
        for (int i = 0; i < NC; i++) m_chunk[i] = m_step(m_chunk[i]);
        done++;
        m_cons++;
`ifdef ABR_KECCAK_ENTROPY_RESEED_EN
        if (m_cons == RI) begin
          m_cons = 0;
          ent_if.rand_consumed_i = 1'b0;
          @(negedge clk_i);
          total++;
          if ({ent_if.rand_valid_o, ent_if.seed_req_o} !== 2'b01) begin
            bad++; $display("FAIL reseed_exit valid_req got=%b exp=01",
                            {ent_if.rand_valid_o, ent_if.seed_req_o});
          end
          reseeded = 1'b1;
          @(posedge clk_i); #1;
          return;
        end
`endif
      end
    end
    ent_if.rand_consumed_i = 1'b0;
    if (done < n) begin
      total++; bad++;
      $display("FAIL consume_timeout done=%0d exp=%0d", done, n);
    end
    @(negedge clk_i);
    total++;
    if (ent_if.rand_valid_o !== 1'b1 || ent_if.rand_data_o !== m_data()) begin
      bad++; $display("FAIL after_consume valid=%b chunk0 got=%h exp=%h", ent_if.rand_valid_o,
                      ent_if.rand_data_o[31:0], m_chunk[0]);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; zeroize = 1'b0; en_i = 1'b0;
    ent_if.seed_ack_i = 1'b0; ent_if.seed_i = 32'h0; ent_if.rand_consumed_i = 1'b0;
    model_clear();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if ({ent_if.seed_req_o, ent_if.rand_valid_o, ent_if.rand_early_o, ent_if.rand_aux_o,
         cons_err, fsm_err} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {ent_if.seed_req_o, ent_if.rand_valid_o,
                      ent_if.rand_early_o, ent_if.rand_aux_o, cons_err, fsm_err});
    end
    total++;
    if (ent_if.rand_data_o !== '0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", ent_if.rand_data_o[31:0]);
    end
    rst_n = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_seed_fill();
    for (int i = 0; i < NC; i++) seed_words[i] = 32'hA5A5_0000 + 32'(i);
    seed_and_fill(1'b1);
    total++;
    if (ent_if.rand_data_o[31:0] !== 32'h52D2_8000) begin
      bad++; $display("FAIL seed_fill_chunk0 got=%h exp=52d28000", ent_if.rand_data_o[31:0]);
    end
  endtask

  task automatic test_zero_seed();
    do_zeroize();
    random_words();
    seed_words[0] = 32'h0;
    seed_and_fill(1'b1);
    total++;
    if (ent_if.rand_data_o[31:0] !== 32'h8020_0003) begin
      bad++; $display("FAIL zero_seed_chunk0 got=%h exp=80200003", ent_if.rand_data_o[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    bit r;
    do_zeroize();
    random_words();
    seed_and_fill(1'b1);
`ifdef ABR_KECCAK_ENTROPY_RESEED_EN
    do_consumes(RI - 1, 1'b0, r);
`else
    do_consumes(10, 1'b0, r);
`endif
  endtask

  task automatic test_reseed();
    bit r;
    do_zeroize();
    random_words();
    seed_and_fill(1'b1);
`ifdef ABR_KECCAK_ENTROPY_RESEED_EN
    do_consumes(RI, 1'b1, r);
    random_words();
    seed_and_fill(1'b0);
    do_consumes(2, 1'b1, r);
`else
    do_consumes(8, 1'b1, r);
`endif
  endtask

  task automatic test_consume_error();
    logic [31:0] w0;
    logic [31:0] w1;
    do_zeroize();
    w0 = $urandom() | 32'h1;
    w1 = $urandom() | 32'h2;
    en_i = 1'b1;
    @(posedge clk_i); #1;
    en_i = 1'b0;
    ent_if.seed_ack_i = 1'b1; ent_if.seed_i = w0;
    @(posedge clk_i); #1;
    ent_if.seed_i = w1;
    @(posedge clk_i); #1;
    ent_if.seed_ack_i = 1'b0;
    m_chunk[0] = w0; m_chunk[1] = w1;
    ent_if.rand_consumed_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (cons_err !== 1'b0) begin
      bad++; $display("FAIL cons_err_early got=%b exp=0", cons_err);
    end
    @(posedge clk_i); #1;
    ent_if.rand_consumed_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (cons_err !== 1'b1 || ent_if.seed_req_o !== 1'b1) begin
      bad++; $display("FAIL cons_err_set err_req got=%b exp=11", {cons_err, ent_if.seed_req_o});
    end
    total++;
    if (ent_if.rand_data_o !== m_data()) begin
      bad++; $display("FAIL cons_err_no_step chunk0 got=%h exp=%h", ent_if.rand_data_o[31:0], m_chunk[0]);
    end
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if (cons_err !== 1'b1) begin
      bad++; $display("FAIL cons_err_sticky got=%b exp=1", cons_err);
    end
    @(posedge clk_i); #1;
    do_zeroize();
    @(negedge clk_i);
    total++;
    if ({cons_err, ent_if.seed_req_o, ent_if.rand_valid_o} !== 3'b000 || ent_if.rand_data_o !== '0) begin
      bad++; $display("FAIL cons_err_zeroize err_req_valid got=%b exp=000 chunk0=%h",
                      {cons_err, ent_if.seed_req_o, ent_if.rand_valid_o}, ent_if.rand_data_o[31:0]);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_zeroize_run();
    bit r;
    do_zeroize();
    random_words();
    seed_and_fill(1'b1);
    do_consumes(2, 1'b1, r);
    do_zeroize();
    @(negedge clk_i);
    total++;
    if ({ent_if.rand_valid_o, ent_if.seed_req_o, ent_if.rand_aux_o} !== 3'b000 ||
        ent_if.rand_data_o !== '0) begin
      bad++; $display("FAIL zeroize_run valid_req_aux got=%b exp=000 chunk0=%h",
                      {ent_if.rand_valid_o, ent_if.seed_req_o, ent_if.rand_aux_o}, ent_if.rand_data_o[31:0]);
    end
    @(posedge clk_i); #1;
    random_words();
    seed_and_fill(1'b1);
    do_consumes(3, 1'b1, r);
  endtask

  initial begin
    test_reset();
    test_seed_fill();
    test_zero_seed();
    test_back_to_back();
    test_reseed();
    test_consume_error();
    test_zeroize_run();
    @(negedge clk_i);
    total++;
    if (fsm_err !== 1'b0 || cons_err !== 1'b0) begin
      bad++; $display("FAIL final_errors fsm_cons got=%b exp=00", {fsm_err, cons_err});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
